// File: rtl/gcd_stein_engine.sv
// Binary (Stein) GCD engine with a valid/ready handshake on both sides.
// Operands are optionally signed. The result is the unsigned GCD plus the number of compute cycles used.
module gcd_stein_engine #(
    parameter int NBits     = 8,
    parameter bit SIGNED_IN = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBits-1:0] xi,
    input  logic [NBits-1:0] yi,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [NBits-1:0] xo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             zero_flag,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int KW = $clog2(NBits) + 1;
    localparam logic [NBits-1:0] ONE_N   = NBits'(1);
    localparam logic [KW-1:0]    ONE_K   = KW'(1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        STRIP,
        CALC,
        FINISH,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [NBits-1:0] a_q, a_d;
    logic [NBits-1:0] b_q, b_d;
    logic [KW-1:0]    k_q, k_d;
    logic [NBits-1:0] xo_q, xo_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [NBits-1:0] mag_x, mag_y;
    logic [CNT_W-1:0] cnt_inc;

    // Two's-complement magnitude; -2^(NBits-1) maps to 2^(NBits-1) as an unsigned value.
    function automatic logic [NBits-1:0] magnitude(input logic [NBits-1:0] v);
        if (SIGNED_IN && v[NBits-1]) begin
            return ~v + ONE_N;
        end
        return v;
    endfunction

    assign mag_x   = magnitude(xi);
    assign mag_y   = magnitude(yi);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ONE_C;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        k_d         = k_q;
        xo_d        = xo_q;
        zero_d      = zero_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = mag_x;
                    b_d        = mag_y;
                    k_d        = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    if (mag_x == '0 || mag_y == '0) begin
                        xo_d        = mag_x | mag_y;
                        zero_d      = (mag_x == '0) && (mag_y == '0);
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        zero_d  = 1'b0;
                        state_d = STRIP;
                    end
                end
            end

            STRIP: begin
                cnt_d = cnt_inc;
                if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + ONE_K;
                end else begin
                    state_d = CALC;
                end
            end

            CALC: begin
                cnt_d = cnt_inc;
                if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q == b_q) begin
                    state_d = FINISH;
                end else if (a_q > b_q) begin
                    // Both odd here, so the difference is even and the shift loses nothing.
                    a_d = (a_q - b_q) >> 1;
                end else begin
                    b_d = (b_q - a_q) >> 1;
                end
            end

            FINISH: begin
                cnt_d       = cnt_inc;
                xo_d        = a_q << k_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            xo_q        <= '0;
            zero_q      <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            k_q         <= k_d;
            xo_q        <= xo_d;
            zero_q      <= zero_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign xo        = xo_q;
    assign zero_flag = zero_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_gcd_stein_engine.sv
// Directed bench for gcd_stein_engine: a signed instance and an unsigned instance, with hand-computed GCDs.
module tb_gcd_stein_engine;

    localparam int N   = 8;
    localparam int CW  = 8;
    localparam int LIM = 2 * N + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [N-1:0]  xi_s, yi_s, xi_u, yi_u;
    logic          iv_s, iv_u, ordy_s, ordy_u;
    logic          ir_s, ir_u, ov_s, ov_u, zf_s, zf_u;
    logic [N-1:0]  xo_s, xo_u;
    logic [CW-1:0] cc_s, cc_u;

    bit            sel;
    logic          ir_c, ov_c, zf_c;
    logic [N-1:0]  xo_c;
    logic [CW-1:0] cc_c;

    assign ir_c = sel ? ir_u : ir_s;
    assign ov_c = sel ? ov_u : ov_s;
    assign zf_c = sel ? zf_u : zf_s;
    assign xo_c = sel ? xo_u : xo_s;
    assign cc_c = sel ? cc_u : cc_s;

    gcd_stein_engine #(.NBits(N), .SIGNED_IN(1'b1), .CNT_W(CW)) dut_s (
        .clk(clk), .rst(rst), .xi(xi_s), .yi(yi_s), .in_valid(iv_s), .in_ready(ir_s),
        .xo(xo_s), .out_valid(ov_s), .out_ready(ordy_s), .zero_flag(zf_s), .cycle_cnt(cc_s)
    );

    gcd_stein_engine #(.NBits(N), .SIGNED_IN(1'b0), .CNT_W(CW)) dut_u (
        .clk(clk), .rst(rst), .xi(xi_u), .yi(yi_u), .in_valid(iv_u), .in_ready(ir_u),
        .xo(xo_u), .out_valid(ov_u), .out_ready(ordy_u), .zero_flag(zf_u), .cycle_cnt(cc_u)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input bit u, input logic [N-1:0] x, input logic [N-1:0] y, input logic v);
        if (u) begin
            xi_u = x; yi_u = y; iv_u = v;
        end else begin
            xi_s = x; yi_s = y; iv_s = v;
        end
    endtask

    task automatic set_ordy(input bit u, input logic r);
        if (u) ordy_u = r;
        else   ordy_s = r;
    endtask

    // Called on a negedge with the selected engine idle. exp_cnt < 0 skips the cycle count check.
    task automatic run_op(input string tag, input bit u, input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic [N-1:0] exp_xo, input bit exp_zf, input int exp_cnt,
                          input int hold);
        int lat;
        sel = u;
        set_ordy(u, hold == 0);
        check({tag, "_in_ready"}, 32'(ir_c), 1);
        drive(u, x, y, 1'b1);
        @(negedge clk);
        drive(u, ~x, ~y, 1'b0);
        lat = 1;
        while (!ov_c && lat < LIM + 2) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_out_valid"}, 32'(ov_c), 1);
        check({tag, "_latency_ok"}, 32'(lat <= LIM), 1);
        check({tag, "_xo"}, 32'(xo_c), 32'(exp_xo));
        check({tag, "_zero_flag"}, 32'(zf_c), 32'(exp_zf));
        if (exp_cnt >= 0) check({tag, "_cycle_cnt"}, 32'(cc_c), 32'(exp_cnt));
        check({tag, "_busy"}, 32'(ir_c), 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(ov_c), 1);
            check({tag, "_hold_xo"}, 32'(xo_c), 32'(exp_xo));
            check({tag, "_hold_busy"}, 32'(ir_c), 0);
        end
        set_ordy(u, 1'b1);
        @(negedge clk);
        check({tag, "_consumed"}, 32'(ov_c), 0);
        check({tag, "_idle"}, 32'(ir_c), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        drive(1'b1, '0, '0, 1'b0);
        ordy_s = 1'b1;
        ordy_u = 1'b1;
        sel    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("reset_in_ready", 32'(ir_s), 1);
        check("reset_out_valid", 32'(ov_s), 0);
        check("reset_xo", 32'(xo_s), 0);
        check("reset_zero_flag", 32'(zf_s), 0);
        check("reset_cycle_cnt", 32'(cc_s), 0);

        // Signed instance
        run_op("g12_18",   1'b0, 8'd12,  8'd18,  8'd6,   1'b0, 6,  0);
        run_op("gm8_12",   1'b0, 8'hF8,  8'd12,  8'd4,   1'b0, 7,  0);
        run_op("gm128x2",  1'b0, 8'h80,  8'h80,  8'h80,  1'b0, -1, 0);
        run_op("g0_0",     1'b0, 8'd0,   8'd0,   8'd0,   1'b1, 0,  0);
        run_op("g0_7",     1'b0, 8'd0,   8'd7,   8'd7,   1'b0, 0,  0);
        run_op("gm128_0",  1'b0, 8'h80,  8'd0,   8'h80,  1'b0, 0,  0);
        run_op("g35_64",   1'b0, 8'd35,  8'd64,  8'd1,   1'b0, -1, 10);

        // Reset during CALC abandons the computation
        sel = 1'b0;
        drive(1'b0, 8'd100, 8'd75, 1'b1);
        @(negedge clk);
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_out_valid", 32'(ov_s), 0);
        check("rst_mid_in_ready", 32'(ir_s), 1);
        check("rst_mid_xo", 32'(xo_s), 0);
        seen = 1'b0;
        for (int i = 0; i < LIM + 4; i++) begin
            @(negedge clk);
            if (ov_s) seen = 1'b1;
        end
        check("rst_mid_no_result", 32'(seen), 0);
        run_op("g9_6",     1'b0, 8'd9,   8'd6,   8'd3,   1'b0, 5,  0);

        // Unsigned instance: top-bit operands are plain magnitudes
        run_op("u200_150", 1'b1, 8'd200, 8'd150, 8'd50,  1'b0, -1, 0);
        run_op("u255_255", 1'b1, 8'd255, 8'd255, 8'd255, 1'b0, 3,  0);
        run_op("u128_96",  1'b1, 8'd128, 8'd96,  8'd32,  1'b0, -1, 0);
        run_op("u17_13",   1'b1, 8'd17,  8'd13,  8'd1,   1'b0, -1, 0);
        run_op("u252_198", 1'b1, 8'd252, 8'd198, 8'd18,  1'b0, -1, 0);
        run_op("u255_1",   1'b1, 8'd255, 8'd1,   8'd1,   1'b0, 10, 0);
        run_op("u0_200",   1'b1, 8'd0,   8'd200, 8'd200, 1'b0, 0,  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
